fb_write_arbiter: RTL and testbench

- Owns the single pixel-write port (x_pos/y_pos/color/en) that feeds xy_to_addr and the frame buffer, in the display_clk domain.
- Sequences a full-screen clear after the frame buffer reports ready, then arbitrates writes round-robin between two requesters: draw (SPI/graphics) and cam (camera preview).
- Replaces ad-hoc init counters; asserts init_done so downstream release logic can key off it.

---
 rtl/fb_pkg.sv | 21 ++
 rtl/fb_clear_sweep.sv | 39 +++
 rtl/fb_write_arbiter.sv | 137 +++++++++++++
 tb/tb_fb_write_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and defaults for the frame-buffer write path.
package fb_pkg;

  localparam int H_RES_DEFAULT   = 640;
  localparam int V_RES_DEFAULT   = 400;
  localparam int COORD_W_DEFAULT = 10;
  localparam int COLOR_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    WAIT_FB,
    CLEAR,
    RUN
  } fb_state_t;

  typedef struct packed {
    logic [COORD_W_DEFAULT-1:0] x;
    logic [COORD_W_DEFAULT-1:0] y;
    logic [COLOR_W_DEFAULT-1:0] color;
  } pixel_req_t;

endpackage

// File: rtl/fb_clear_sweep.sv
// Raster x/y counter: restarts at (0,0) on start, advances one pixel per step,
// x fastest; done pulses on the step that covers the last pixel.
module fb_clear_sweep #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 400,
  parameter int COORD_W = 10
) (
  input  logic               display_clk,
  input  logic               reset_n_byte,
  input  logic               start,
  input  logic               step,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               done
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_RES - 1);

  assign done = step && (x == X_LAST) && (y == Y_LAST);

  always_ff @(posedge display_clk or negedge reset_n_byte) begin
    if (!reset_n_byte) begin
      x <= '0;
      y <= '0;
    end else if (start) begin
      x <= '0;
      y <= '0;
    end else if (step) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Owns the frame-buffer pixel-write port: power-up/requested clears, then
// round-robin arbitration between draw and cam requesters.
//   state   | meaning
//   WAIT_FB | frame buffer not ready; port idle
//   CLEAR   | full-screen sweep with latched clear colour
//   RUN     | arbitrating draw/cam pixel writes
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int                 H_RES       = H_RES_DEFAULT,
  parameter int                 V_RES       = V_RES_DEFAULT,
  parameter int                 COORD_W     = 10,
  parameter int                 COLOR_W     = 4,
  parameter logic [COLOR_W-1:0] RESET_COLOR = '0
) (
  input  logic               display_clk,
  input  logic               reset_n_byte,
  input  logic               fb_ready,
  input  logic               clear_req,
  input  logic [COLOR_W-1:0] clear_color,
  input  logic               draw_valid,
  output logic               draw_ready,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  input  logic [COLOR_W-1:0] draw_color,
  input  logic               cam_valid,
  output logic               cam_ready,
  input  logic [COORD_W-1:0] cam_x,
  input  logic [COORD_W-1:0] cam_y,
  input  logic [COLOR_W-1:0] cam_color,
  output logic [COORD_W-1:0] x_pos,
  output logic [COORD_W-1:0] y_pos,
  output logic [COLOR_W-1:0] color,
  output logic               en,
  output logic               busy,
  output logic               init_done,
  output logic [7:0]         drop_count
);

  localparam logic [COORD_W:0] H_LIM = (COORD_W + 1)'(H_RES);
  localparam logic [COORD_W:0] V_LIM = (COORD_W + 1)'(V_RES);

  fb_state_t          state, state_next;
  logic               rr_ptr;
  logic [COLOR_W-1:0] clr_color;
  logic [COORD_W-1:0] sweep_x, sweep_y;
  logic               sweep_done, clearing;
  logic               grant_draw, grant_cam, arb_open, xfer, in_range;
  pixel_req_t         sel;

  assign clearing = (state == CLEAR) && fb_ready;

  fb_clear_sweep #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .COORD_W(COORD_W)
  ) u_sweep (
    .display_clk (display_clk),
    .reset_n_byte(reset_n_byte),
    .start       (state != CLEAR),
    .step        (clearing),
    .x           (sweep_x),
    .y           (sweep_y),
    .done        (sweep_done)
  );

  // busy still high means the last clear pixel is on the port; hold grants off.
  assign arb_open = (state == RUN) && fb_ready && !busy;

  always_comb begin
    state_next = state;
    grant_draw = 1'b0;
    grant_cam  = 1'b0;
    sel        = '{x: draw_x, y: draw_y, color: draw_color};
    if (arb_open) begin
      if (draw_valid && (!cam_valid || !rr_ptr)) grant_draw = 1'b1;
      else if (cam_valid)                        grant_cam  = 1'b1;
    end
    if (grant_cam) sel = '{x: cam_x, y: cam_y, color: cam_color};
    case (state)
      WAIT_FB: if (fb_ready) state_next = CLEAR;
      CLEAR: begin
        if (!fb_ready)       state_next = WAIT_FB;
        else if (sweep_done) state_next = RUN;
      end
      RUN: begin
        if (!fb_ready)      state_next = WAIT_FB;
        else if (clear_req) state_next = CLEAR;
      end
      default: state_next = WAIT_FB;
    endcase
  end

  assign draw_ready = grant_draw;
  assign cam_ready  = grant_cam;
  assign xfer       = grant_draw || grant_cam;
  assign in_range   = ({1'b0, sel.x} < H_LIM) && ({1'b0, sel.y} < V_LIM);

  always_ff @(posedge display_clk or negedge reset_n_byte) begin
    if (!reset_n_byte) begin
      state      <= WAIT_FB;
      rr_ptr     <= 1'b0;
      clr_color  <= RESET_COLOR;
      x_pos      <= '0;
      y_pos      <= '0;
      color      <= '0;
      en         <= 1'b0;
      busy       <= 1'b0;
      init_done  <= 1'b0;
      drop_count <= '0;
    end else begin
      state <= state_next;
      en    <= 1'b0;
      busy  <= clearing;
      if ((state == RUN) && busy) init_done <= 1'b1;
      if (clearing) begin
        en    <= 1'b1;
        x_pos <= sweep_x;
        y_pos <= sweep_y;
        color <= clr_color;
      end else if (xfer) begin
        rr_ptr <= ~rr_ptr;
        if (in_range) begin
          en    <= 1'b1;
          x_pos <= sel.x;
          y_pos <= sel.y;
          color <= sel.color;
        end else if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 1'b1;
        end
      end
      if ((state == WAIT_FB) && fb_ready)              clr_color <= RESET_COLOR;
      else if ((state == RUN) && fb_ready && clear_req) clr_color <= clear_color;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter on an 8x4 screen.
module tb_fb_write_arbiter;
  localparam int H = 8;
  localparam int V = 4;

  logic       display_clk = 1'b0;
  logic       reset_n_byte = 1'b0;
  logic       fb_ready = 1'b0, clear_req = 1'b0;
  logic [3:0] clear_color = '0;
  logic       draw_valid = 1'b0, cam_valid = 1'b0;
  logic [9:0] draw_x = '0, draw_y = '0, cam_x = '0, cam_y = '0;
  logic [3:0] draw_color = '0, cam_color = '0;
  logic       draw_ready, cam_ready, en, busy, init_done;
  logic [9:0] x_pos, y_pos;
  logic [3:0] color;
  logic [7:0] drop_count;

  always #5 display_clk = ~display_clk;

  fb_write_arbiter #(.H_RES(H), .V_RES(V), .COORD_W(10), .COLOR_W(4), .RESET_COLOR(4'd0)) dut (
    .display_clk(display_clk), .reset_n_byte(reset_n_byte), .fb_ready(fb_ready),
    .clear_req(clear_req), .clear_color(clear_color),
    .draw_valid(draw_valid), .draw_ready(draw_ready), .draw_x(draw_x), .draw_y(draw_y),
    .draw_color(draw_color), .cam_valid(cam_valid), .cam_ready(cam_ready), .cam_x(cam_x),
    .cam_y(cam_y), .cam_color(cam_color), .x_pos(x_pos), .y_pos(y_pos), .color(color),
    .en(en), .busy(busy), .init_done(init_done), .drop_count(drop_count));

  typedef struct {int x; int y; int c;} pix_t;
  pix_t exp_q[$];
  int checks = 0, errors = 0;

  // Reference model: mode 0 waiting, 1 clearing, 2 running; n = next sweep pixel index.
  int m_mode = 0, m_n = 0, m_col = 0, m_ptr = 0, m_drop = 0;
  bit m_busy = 0, m_init = 0, m_last_pend = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge display_clk) begin
    if (reset_n_byte && en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_en", 1, 0);
      end else begin
        pix_t p;
        p = exp_q.pop_front();
        chk("pix_x", int'(x_pos), p.x);
        chk("pix_y", int'(y_pos), p.y);
        chk("pix_color", int'(color), p.c);
      end
    end
  end

  function automatic void grants(output bit gd, output bit gc);
    bit open;
    open = (m_mode == 2) && fb_ready && !m_busy;
    gd = open && draw_valid && (!cam_valid || m_ptr == 0);
    gc = open && cam_valid && !gd;
  endfunction

  function automatic void model_update(input bit gd, input bit gc);
    bit nb;
    int px, py, pc;
    nb = (m_mode == 1) && fb_ready;
    if (m_last_pend) m_init = 1;
    m_last_pend = 0;
    if (nb) begin
      exp_q.push_back('{m_n % H, m_n / H, m_col});
      if (m_n == H * V - 1) m_last_pend = 1;
    end
    if (gd || gc) begin
      px = gd ? int'(draw_x) : int'(cam_x);
      py = gd ? int'(draw_y) : int'(cam_y);
      pc = gd ? int'(draw_color) : int'(cam_color);
      if (px < H && py < V) exp_q.push_back('{px, py, pc});
      else if (m_drop < 255) m_drop++;
      m_ptr ^= 1;
    end
    case (m_mode)
      0: if (fb_ready) begin m_mode = 1; m_n = 0; m_col = 0; end
      1: if (!fb_ready) m_mode = 0; else if (m_n == H * V - 1) m_mode = 2; else m_n++;
      default: if (!fb_ready) m_mode = 0;
               else if (clear_req) begin m_mode = 1; m_n = 0; m_col = int'(clear_color); end
    endcase
    m_busy = nb;
  endfunction

  task automatic cyc();
    bit gd, gc;
    #1;
    grants(gd, gc);
    chk("draw_ready", int'(draw_ready), int'(gd));
    chk("cam_ready", int'(cam_ready), int'(gc));
    @(posedge display_clk);
    model_update(gd, gc);
    @(negedge display_clk);
    chk("busy", int'(busy), int'(m_busy));
    chk("init_done", int'(init_done), int'(m_init));
    chk("drop_count", int'(drop_count), m_drop);
  endtask

  initial begin
    // Reset with valids and fb_ready high: everything must stay quiet.
    draw_valid = 1; cam_valid = 1; fb_ready = 1;
    @(negedge display_clk); @(negedge display_clk);
    chk("rst_en", int'(en), 0);          chk("rst_busy", int'(busy), 0);
    chk("rst_init", int'(init_done), 0); chk("rst_drop", int'(drop_count), 0);
    chk("rst_x", int'(x_pos), 0);        chk("rst_y", int'(y_pos), 0);
    chk("rst_color", int'(color), 0);    chk("rst_dready", int'(draw_ready), 0);
    chk("rst_cready", int'(cam_ready), 0);
    draw_valid = 0; cam_valid = 0; fb_ready = 0;
    reset_n_byte = 1;

    // Power-up clear; clear_req in WAIT_FB and mid-clear must be ignored.
    repeat (4) cyc();
    fb_ready = 1; clear_req = 1; clear_color = 4'd7;
    cyc();
    clear_req = 0;
    for (int i = 0; i < 40; i++) begin
      clear_req = (i == 10); clear_color = 4'd3;
      cyc();
    end
    clear_req = 0;
    chk("init_after_clear", int'(init_done), 1);

    // Single draw.
    draw_valid = 1; draw_x = 10'd3; draw_y = 10'd2; draw_color = 4'd5;
    cyc();
    draw_valid = 0;
    repeat (2) cyc();

    // Both valid: alternating grants.
    draw_valid = 1; cam_valid = 1; draw_color = 4'd1; cam_color = 4'd2;
    for (int i = 0; i < 4; i++) begin
      draw_x = 10'($urandom_range(0, H - 1)); draw_y = 10'($urandom_range(0, V - 1));
      cam_x  = 10'($urandom_range(0, H - 1)); cam_y  = 10'($urandom_range(0, V - 1));
      cyc();
    end
    draw_valid = 0; cam_valid = 0;
    repeat (2) cyc();

    // Out-of-range requests, then saturation.
    cam_valid = 1; cam_x = 10'd8; cam_y = 10'd0; cyc();
    cam_x = 10'd2; cam_y = 10'd4; cyc();
    cam_valid = 0; cyc();
    chk("drop_two", int'(drop_count), 2);
    cam_valid = 1;
    for (int i = 0; i < 300; i++) begin
      cam_x = 10'($urandom_range(H, 1023)); cam_y = 10'($urandom_range(0, 1023));
      cyc();
    end
    cam_valid = 0; cyc();
    chk("drop_sat", int'(drop_count), 255);

    // clear_req together with a draw transfer; draw kept pending during the clear.
    draw_valid = 1; draw_x = 10'd6; draw_y = 10'd1; draw_color = 4'd5;
    clear_req = 1; clear_color = 4'd9;
    cyc();
    clear_req = 0;
    for (int i = 0; i < 40; i++) begin
      draw_x = 10'($urandom_range(0, H - 1)); draw_y = 10'($urandom_range(0, V - 1));
      draw_color = 4'($urandom);
      cyc();
    end
    draw_valid = 0;

    // Randomised traffic with occasional clears and out-of-range pixels.
    for (int i = 0; i < 300; i++) begin
      draw_valid = 1'($urandom); cam_valid = 1'($urandom);
      draw_x = 10'($urandom_range(0, 9)); draw_y = 10'($urandom_range(0, 5));
      cam_x  = 10'($urandom_range(0, 9)); cam_y  = 10'($urandom_range(0, 5));
      draw_color = 4'($urandom); cam_color = 4'($urandom);
      clear_req = ($urandom_range(0, 63) == 0); clear_color = 4'($urandom);
      cyc();
    end
    draw_valid = 0; cam_valid = 0; clear_req = 0;

    // fb_ready loss mid-clear, then a fresh sweep with the reset colour.
    for (int i = 0; i < 100 && !(m_mode == 2 && !m_busy); i++) cyc();
    clear_req = 1; clear_color = 4'd6;
    cyc();
    clear_req = 0;
    for (int i = 0; i < 100 && !(m_mode == 1 && m_n == 10); i++) cyc();
    checks++;
    if (!(m_mode == 1 && m_n == 10)) begin
      errors++;
      $display("FAIL reach_pixel10 actual_mode=%0d actual_n=%0d required n=10", m_mode, m_n);
    end
    fb_ready = 0;
    repeat (3) cyc();
    fb_ready = 1;
    repeat (45) cyc();
    chk("init_retained", int'(init_done), 1);
    repeat (3) cyc();
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
